max7219_rx: RTL and testbench

- Receive-side model of the MAX7219 serial interface, the far end of the display driver's sck/din/cs link.
- Oversamples the three serial lines on the system clock and shifts din in MSB-first on sck rising edges while cs is low.
- On cs rising edge, latches the last 16 bits as one frame and applies it to a MAX7219-compatible register file.
- Used as the display stand-in for bench/FPGA self-checking of the display driver, and as a frame monitor.

---
 rtl/max7219_rx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_max7219_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_rx.sv
// max7219_rx: receive side of a MAX7219 sck/din/cs link.
// Oversamples the serial lines on clock, assembles 16-bit frames and applies
// them to a MAX7219-compatible register file.
module max7219_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sck,
  input  logic        din,
  input  logic        cs,
  output logic        busy,
  output logic        frame_valid,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic        short_frame,
  output logic [63:0] digits,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  // Frame bits [15:12] are don't-care, so only the low 12 bits are retained.
  localparam int unsigned KEEP_W     = 12;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Synchronizer chains
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;

  logic w_sck;
  logic w_din;
  logic w_cs;

  // Edge detection, registered so the data bit stays aligned with its edge
  logic r_sck_d;
  logic r_cs_d;
  logic r_sck_rise;
  logic r_cs_rise;
  logic r_cs_fall;
  logic r_din_q;

  // Frame assembly
  logic [KEEP_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;

  // FSM
  state_t r_state;
  state_t w_state_nxt;

  // Commit fields taken from the assembled frame
  logic [ADDR_W-1:0] w_cmt_addr;
  logic [DATA_W-1:0] w_cmt_data;

  // Output registers and their next values
  logic        r_busy;
  logic        r_frame_valid;
  logic [3:0]  r_frame_addr;
  logic [7:0]  r_frame_data;
  logic        r_short_frame;
  logic [63:0] r_digits;
  logic [7:0]  r_decode_mode;
  logic [3:0]  r_intensity;
  logic [2:0]  r_scan_limit;
  logic        r_shutdown_n;
  logic        r_display_test;

  logic        w_busy_nxt;
  logic        w_frame_valid_nxt;
  logic [3:0]  w_frame_addr_nxt;
  logic [7:0]  w_frame_data_nxt;
  logic        w_short_frame_nxt;
  logic [63:0] w_digits_nxt;
  logic [7:0]  w_decode_mode_nxt;
  logic [3:0]  w_intensity_nxt;
  logic [2:0]  w_scan_limit_nxt;
  logic        w_shutdown_n_nxt;
  logic        w_display_test_nxt;

  assign w_sck = r_sck_sync[SYNC_STAGES-1];
  assign w_din = r_din_sync[SYNC_STAGES-1];
  assign w_cs  = r_cs_sync[SYNC_STAGES-1];

  assign w_cmt_addr = r_shift[11:8];
  assign w_cmt_data = r_shift[7:0];

  // Input synchronizers; din uses the same depth to stay aligned with sck
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sck_sync <= '0;
      r_din_sync <= '0;
      r_cs_sync  <= '0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], din};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs};
    end
  end

  // Edge detectors on the synchronized lines, with din captured alongside
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b0;
      r_sck_rise <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_din_q    <= 1'b0;
    end else begin
      r_sck_d    <= w_sck;
      r_cs_d     <= w_cs;
      r_sck_rise <= w_sck & ~r_sck_d;
      r_cs_rise  <= w_cs & ~r_cs_d;
      r_cs_fall  <= ~w_cs & r_cs_d;
      r_din_q    <= w_din;
    end
  end

  // Shift register and saturating bit counter; cs fall starts a fresh frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_cs_fall) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if ((r_state == ST_SHIFT) && r_sck_rise && !r_cs_rise) begin
      r_shift <= {r_shift[KEEP_W-2:0], r_din_q};
      if (r_bit_cnt != CNT_W'(FRAME_BITS)) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; a cs fall during COMMIT goes straight back to SHIFT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_cs_fall) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cs_rise) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (r_cs_fall) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: frame commit and register-file decode
  always_comb begin
    w_busy_nxt         = (w_state_nxt == ST_SHIFT);
    w_frame_valid_nxt  = 1'b0;
    w_short_frame_nxt  = 1'b0;
    w_frame_addr_nxt   = r_frame_addr;
    w_frame_data_nxt   = r_frame_data;
    w_digits_nxt       = r_digits;
    w_decode_mode_nxt  = r_decode_mode;
    w_intensity_nxt    = r_intensity;
    w_scan_limit_nxt   = r_scan_limit;
    w_shutdown_n_nxt   = r_shutdown_n;
    w_display_test_nxt = r_display_test;

    if (r_state == ST_COMMIT) begin
      if (r_bit_cnt == CNT_W'(FRAME_BITS)) begin
        w_frame_valid_nxt = 1'b1;
        w_frame_addr_nxt  = w_cmt_addr;
        w_frame_data_nxt  = w_cmt_data;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (w_cmt_addr == ADDR_W'(i + 1)) begin
            w_digits_nxt[i*DATA_W +: DATA_W] = w_cmt_data;
          end
        end
        case (w_cmt_addr)
          4'h9: w_decode_mode_nxt  = w_cmt_data;
          4'hA: w_intensity_nxt    = w_cmt_data[3:0];
          4'hB: w_scan_limit_nxt   = w_cmt_data[2:0];
          4'hC: w_shutdown_n_nxt   = w_cmt_data[0];
          4'hF: w_display_test_nxt = w_cmt_data[0];
          default: begin
          end
        endcase
      end else begin
        w_short_frame_nxt = 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy         <= 1'b0;
      r_frame_valid  <= 1'b0;
      r_frame_addr   <= '0;
      r_frame_data   <= '0;
      r_short_frame  <= 1'b0;
      r_digits       <= '0;
      r_decode_mode  <= '0;
      r_intensity    <= '0;
      r_scan_limit   <= '0;
      r_shutdown_n   <= 1'b0;
      r_display_test <= 1'b0;
    end else begin
      r_busy         <= w_busy_nxt;
      r_frame_valid  <= w_frame_valid_nxt;
      r_frame_addr   <= w_frame_addr_nxt;
      r_frame_data   <= w_frame_data_nxt;
      r_short_frame  <= w_short_frame_nxt;
      r_digits       <= w_digits_nxt;
      r_decode_mode  <= w_decode_mode_nxt;
      r_intensity    <= w_intensity_nxt;
      r_scan_limit   <= w_scan_limit_nxt;
      r_shutdown_n   <= w_shutdown_n_nxt;
      r_display_test <= w_display_test_nxt;
    end
  end

  assign busy         = r_busy;
  assign frame_valid  = r_frame_valid;
  assign frame_addr   = r_frame_addr;
  assign frame_data   = r_frame_data;
  assign short_frame  = r_short_frame;
  assign digits       = r_digits;
  assign decode_mode  = r_decode_mode;
  assign intensity    = r_intensity;
  assign scan_limit   = r_scan_limit;
  assign shutdown_n   = r_shutdown_n;
  assign display_test = r_display_test;

endmodule

// File: tb/tb_max7219_rx.sv
// Scoreboard bench for max7219_rx: stimulus pushes expected commits, a monitor
// pops and compares them whenever the receiver pulses frame_valid/short_frame.
module tb_max7219_rx;

  localparam int unsigned SYNC_STAGES = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sck   = 1'b0;
  logic        din   = 1'b0;
  logic        cs    = 1'b1;
  logic        busy;
  logic        frame_valid;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        short_frame;
  logic [63:0] digits;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n;
  logic        display_test;

  int n_checks = 0;
  int n_errors = 0;

  max7219_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clock        (clock),
    .reset        (reset),
    .sck          (sck),
    .din          (din),
    .cs           (cs),
    .busy         (busy),
    .frame_valid  (frame_valid),
    .frame_addr   (frame_addr),
    .frame_data   (frame_data),
    .short_frame  (short_frame),
    .digits       (digits),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown_n   (shutdown_n),
    .display_test (display_test)
  );

  always #5 clock = ~clock;

  // Expected state of the receiver after one commit event
  typedef struct {
    bit          is_valid;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [63:0] digits;
    logic [7:0]  decode;
    logic [3:0]  inten;
    logic [2:0]  scan;
    logic        shut;
    logic        test;
  } exp_t;

  exp_t q[$];

  // Reference model: a plain 16-entry byte register file plus last frame
  logic [7:0] m_reg [16];
  logic [3:0] m_addr;
  logic [7:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t snap(input bit v);
    exp_t e;
    e.is_valid = v;
    e.addr     = m_addr;
    e.data     = m_data;
    for (int i = 0; i < 8; i++) e.digits[i*8 +: 8] = m_reg[i+1];
    e.decode   = m_reg[9];
    e.inten    = m_reg[10][3:0];
    e.scan     = m_reg[11][2:0];
    e.shut     = m_reg[12][0];
    e.test     = m_reg[15][0];
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
    m_addr = 4'h0;
    m_data = 8'h00;
  endtask

  // Receiver keeps the last 16 bits; 0x0, 0xD, 0xE write nothing
  task automatic model_frame(input logic [31:0] bits, input int n);
    logic [15:0] v;
    if (n >= 16) begin
      v      = bits[15:0];
      m_addr = v[11:8];
      m_data = v[7:0];
      if (m_addr != 4'h0 && m_addr != 4'hD && m_addr != 4'hE) m_reg[m_addr] = m_data;
      q.push_back(snap(1'b1));
    end else begin
      q.push_back(snap(1'b0));
    end
  endtask

  task automatic compare_state(input string tag, input exp_t e);
    check({tag, "_addr"},      64'(frame_addr),   64'(e.addr));
    check({tag, "_data"},      64'(frame_data),   64'(e.data));
    check({tag, "_digits"},    digits,            e.digits);
    check({tag, "_decode"},    64'(decode_mode),  64'(e.decode));
    check({tag, "_intensity"}, 64'(intensity),    64'(e.inten));
    check({tag, "_scan"},      64'(scan_limit),   64'(e.scan));
    check({tag, "_shutdown"},  64'(shutdown_n),   64'(e.shut));
    check({tag, "_test"},      64'(display_test), 64'(e.test));
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (reset && (frame_valid || short_frame)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 64'({frame_valid, short_frame}), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind", 64'({frame_valid, short_frame}), e.is_valid ? 64'(2) : 64'(1));
        compare_state("commit", e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din = bits[i];
      tick($urandom_range(3, 5));
      sck = 1'b1;
      tick($urandom_range(3, 5));
      sck = 1'b0;
    end
  endtask

  // One cs-framed transfer; optionally measures cs-rise to frame_valid latency
  task automatic send_frame(input logic [31:0] bits, input int n, input bit measure);
    int lat;
    model_frame(bits, n);
    @(negedge clock);
    cs  = 1'b0;
    sck = 1'b0;
    tick($urandom_range(4, 6));
    check("busy_in_frame", 64'(busy), 64'(1));
    send_bits(bits, n);
    tick($urandom_range(3, 5));
    din = 1'($urandom());
    cs  = 1'b1;
    if (measure) begin
      lat = 0;
      @(posedge clock);
      for (int k = 1; k <= 12; k++) begin
        @(posedge clock);
        #1;
        if (frame_valid) begin
          lat = k;
          break;
        end
      end
      check("valid_latency", 64'(lat), 64'(SYNC_STAGES + 2));
    end else begin
      tick($urandom_range(3, 6));
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 200) begin
      tick(1);
      w++;
    end
    check("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bits;
    int          n;
    int          sel;

    model_reset();

    // Power-on reset
    tick(3);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(frame_valid), 64'(0));
    compare_state("rst", snap(1'b0));
    reset = 1'b1;
    tick(10);
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_valid", 64'({frame_valid, short_frame}), 64'(0));
    compare_state("post_rst", snap(1'b0));

    // Control registers
    send_frame(32'h0C01, 16, 1'b0);
    send_frame(32'h0A05, 16, 1'b0);
    send_frame(32'h0B07, 16, 1'b0);
    drain();
    check("dir_shutdown", 64'(shutdown_n), 64'(1));
    check("dir_intensity", 64'(intensity), 64'(5));
    check("dir_scan", 64'(scan_limit), 64'(7));
    check("dir_addr", 64'(frame_addr), 64'(4'hB));
    check("dir_data", 64'(frame_data), 64'(8'h07));

    // Digit registers, then decode mode
    for (int k = 1; k <= 8; k++) send_frame(32'((k << 8) | (k - 1)), 16, 1'b0);
    send_frame(32'h0903, 16, 1'b0);
    drain();
    check("dir_digits", digits, 64'h0706050403020100);
    check("dir_decode", 64'(decode_mode), 64'(3));

    // Short frame leaves everything unchanged
    send_frame(32'h0ABC, 12, 1'b0);
    drain();
    check("short_intensity", 64'(intensity), 64'(5));

    // Shift-through of a 20-bit transfer plus commit latency
    send_frame(32'h000A0F01, 20, 1'b1);
    drain();
    check("dir_display_test", 64'(display_test), 64'(1));

    // Random traffic: mostly full frames, some short and some long
    for (int t = 0; t < 40; t++) begin
      bits = $urandom();
      sel  = $urandom_range(0, 9);
      if (sel == 0)      n = $urandom_range(1, 15);
      else if (sel == 1) n = $urandom_range(17, 20);
      else               n = 16;
      send_frame(bits, n, 1'b0);
    end
    drain();
    compare_state("rand_final", snap(1'b0));

    // Reset in mid-frame discards the partial frame
    @(negedge clock);
    cs = 1'b0;
    tick(5);
    send_bits(32'hFF, 8);
    reset = 1'b0;
    tick(2);
    model_reset();
    compare_state("mid_rst", snap(1'b0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    cs  = 1'b1;
    sck = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(8);
    check("mid_rst_release_busy", 64'(busy), 64'(0));
    send_frame(32'h0A09, 16, 1'b0);
    drain();
    check("after_rst_intensity", 64'(intensity), 64'(9));
    check("after_rst_digits", digits, 64'(0));
    check("after_rst_shutdown", 64'(shutdown_n), 64'(0));
    compare_state("after_rst", snap(1'b0));

    tick(5);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
